seq_restoring_divider: RTL

- Sequential restoring divider; the inverse datapath of the team's sequential multiplier.
- Divides a 2*WIDTH-bit dividend, such as a multiplier product, by a WIDTH-bit divisor. Produces a WIDTH-bit quotient and a WIDTH-bit remainder.
- Latency is constant and data-independent, so the divider can be instantiated in pairs inside the timing-leak tester next to the multipliers.
- Uses the same start/done handshake style as the multiplier.

---
 rtl/seq_restoring_divider.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, fixed WIDTH-cycle latency.
// Optional macro SEQ_DIV_SELFCHECK_EN adds a checkFail output that re-multiplies the finished result.
module seq_restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 quotientDone,
    output logic                 busy,
    output logic                 divError
`ifdef SEQ_DIV_SELFCHECK_EN
    ,
    output logic                 checkFail
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             stateReg;
    logic [WIDTH:0]     remReg;
    logic [WIDTH-1:0]   quoReg;
    logic [WIDTH-1:0]   divisorReg;
    logic               errReg;
    logic [CW-1:0]      cntReg;

    logic [WIDTH:0]     remShift;
    logic [WIDTH+1:0]   trial;
    logic               trialOk;
    logic [WIDTH:0]     remNext;
    logic [WIDTH-1:0]   quoNext;
    logic [WIDTH-1:0]   quoFinal;
    logic [WIDTH-1:0]   remFinal;
    logic               lastIter;

    // One restoring step; the extra top bit of trial is the borrow.
    assign remShift = {remReg[WIDTH-1:0], quoReg[WIDTH-1]};
    assign trial    = {1'b0, remShift} - {2'b00, divisorReg};
    assign trialOk  = ~trial[WIDTH+1];
    assign remNext  = trialOk ? trial[WIDTH:0] : remShift;
    assign quoNext  = {quoReg[WIDTH-2:0], trialOk};
    assign lastIter = (cntReg == CW'(WIDTH - 1));

    // Overflow saturates the quotient and zeroes the remainder; the datapath still runs so timing is constant.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_final
            assign quoFinal[gi] = errReg | quoNext[gi];
            assign remFinal[gi] = ~errReg & remNext[gi];
        end
    endgenerate

`ifdef SEQ_DIV_SELFCHECK_EN
    localparam int PW = 2 * WIDTH + 1;
    logic [2*WIDTH-1:0] dividendReg;
    logic [PW-1:0]      recon;

    assign recon     = PW'(quotient) * PW'(divisorReg) + PW'(remainder);
    assign checkFail = quotientDone & ~divError &
                       ((recon != {1'b0, dividendReg}) | (remainder >= divisorReg));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg     <= IDLE;
            remReg       <= '0;
            quoReg       <= '0;
            divisorReg   <= '0;
            errReg       <= 1'b0;
            cntReg       <= '0;
            quotient     <= '0;
            remainder    <= '0;
            quotientDone <= 1'b0;
            busy         <= 1'b0;
            divError     <= 1'b0;
`ifdef SEQ_DIV_SELFCHECK_EN
            dividendReg  <= '0;
`endif
        end else begin
            case (stateReg)
                IDLE, DONE: begin
                    if (start) begin
                        remReg       <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
                        quoReg       <= dividend[WIDTH-1:0];
                        divisorReg   <= divisor;
                        errReg       <= (dividend[2*WIDTH-1:WIDTH] >= divisor);
                        cntReg       <= '0;
                        quotientDone <= 1'b0;
                        busy         <= 1'b1;
                        stateReg     <= BUSY;
`ifdef SEQ_DIV_SELFCHECK_EN
                        dividendReg  <= dividend;
`endif
                    end
                end
                BUSY: begin
                    remReg <= remNext;
                    quoReg <= quoNext;
                    cntReg <= cntReg + 1'b1;
                    if (lastIter) begin
                        quotient     <= quoFinal;
                        remainder    <= remFinal;
                        divError     <= errReg;
                        quotientDone <= 1'b1;
                        busy         <= 1'b0;
                        stateReg     <= DONE;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule
